// File: rtl/nand_cpu_pkg.sv
// nand_cpu_pkg: types and constants shared by the load/store path.
//   NUM_REG / REG_AW : physical register count and its address width
//   MemOp            : memory operation carried from mem_buffer
//   LsuState         : load_store_unit FSM states
package nand_cpu_pkg;

  localparam int NUM_REG = 16;
  localparam int REG_AW  = $clog2(NUM_REG);

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2,
    MEM_FENCE = 2'd3
  } MemOp;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    WB    = 3'd3,
    DRAIN = 3'd4
  } LsuState;

endpackage

// File: rtl/lsu_wb_ifc.sv
// lsu_wb_ifc: writeback bundle between load_store_unit and the writeback arbiter.
//   wb_valid / wb_ready : writeback handshake
//   wb_rw_addr          : destination physical register
//   wb_data             : load result
//   modport out : producer side (load_store_unit)
//   modport in  : consumer side (arbiter)
interface lsu_wb_ifc #(
  parameter int DATA_W = 16,
  parameter int REG_AW = nand_cpu_pkg::REG_AW
) ();
  logic              wb_valid;
  logic              wb_ready;
  logic [REG_AW-1:0] wb_rw_addr;
  logic [DATA_W-1:0] wb_data;

  modport out (output wb_valid, output wb_rw_addr, output wb_data, input wb_ready);
  modport in  (input wb_valid, input wb_rw_addr, input wb_data, output wb_ready);
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: executes one load/store at a time for the OoO core.
// Accepts an issued op from mem_buffer, forms base+offset (modulo wrap),
// issues a valid/ready request to data memory and returns load data to
// writeback. Flush cancels in-flight loads; stores always complete.
//
// Ports:
//   clk, rst (sync, active-high), flush (one-cycle cancel pulse)
//   in_*      : issue handshake and operands from mem_buffer
//   dmem_req_*: memory request handshake; dmem_resp_*: load return
//   wb_*      : writeback handshake, store_done pulse, busy
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a new op
// REQ   | request presented to memory, fields held until accepted
// WAIT  | load accepted, waiting for the response
// WB    | load result presented to writeback
// DRAIN | flushed load still owed a response; swallow it
module load_store_unit
  import nand_cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  MemOp              in_mem_op,
  input  logic [DATA_W-1:0] in_base,
  input  logic [DATA_W-1:0] in_offset,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic              in_use_rw,
  input  logic [REG_AW-1:0] in_rw_addr,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [ADDR_W-1:0] dmem_req_addr,
  output logic [DATA_W-1:0] dmem_req_wdata,
  input  logic              dmem_resp_valid,
  input  logic [DATA_W-1:0] dmem_resp_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_rw_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              store_done,
  output logic              busy
);

  LsuState r_state;
  LsuState w_next_state;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_use_rw;
  logic [REG_AW-1:0] r_rw_addr;
  logic [DATA_W-1:0] r_rdata;
  logic              r_store_done;

  logic [DATA_W-1:0] w_ea_full;
  logic              w_accept;
  logic              w_is_mem_op;

  assign w_ea_full   = in_base + in_offset;
  assign w_accept    = (r_state == IDLE) && in_valid && !flush;
  assign w_is_mem_op = (in_mem_op == MEM_LOAD) || (in_mem_op == MEM_STORE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_is_mem_op) w_next_state = REQ;
      end
      REQ: begin
        if (dmem_req_ready) begin
          if (r_we)       w_next_state = IDLE;
          else if (flush) w_next_state = DRAIN;
          else            w_next_state = WAIT;
        end else if (flush && !r_we) begin
          // request not yet taken by memory, safe to withdraw
          w_next_state = IDLE;
        end
      end
      WAIT: begin
        if (dmem_resp_valid) begin
          if (flush || !r_use_rw) w_next_state = IDLE;
          else                    w_next_state = WB;
        end else if (flush) begin
          w_next_state = DRAIN;
        end
      end
      WB: begin
        if (flush || wb_ready) w_next_state = IDLE;
      end
      DRAIN: begin
        if (dmem_resp_valid) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake outputs decode the state only; rst masks them during the
  // first reset cycle before the state register has cleared.
  always_comb begin
    in_ready       = 1'b0;
    dmem_req_valid = 1'b0;
    wb_valid       = 1'b0;
    busy           = 1'b0;
    if (!rst) begin
      in_ready       = (r_state == IDLE);
      dmem_req_valid = (r_state == REQ);
      wb_valid       = (r_state == WB);
      busy           = (r_state != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_use_rw     <= 1'b0;
      r_rw_addr    <= '0;
      r_rdata      <= '0;
      r_store_done <= 1'b0;
    end else begin
      r_store_done <= (r_state == REQ) && r_we && dmem_req_ready;
      if (w_accept) begin
        r_we      <= (in_mem_op == MEM_STORE);
        r_addr    <= ADDR_W'(w_ea_full);
        r_wdata   <= in_store_data;
        r_use_rw  <= in_use_rw;
        r_rw_addr <= in_rw_addr;
      end
      if ((r_state == WAIT) && dmem_resp_valid && !flush) r_rdata <= dmem_resp_rdata;
    end
  end

  assign dmem_req_we    = r_we;
  assign dmem_req_addr  = r_addr;
  assign dmem_req_wdata = r_wdata;
  assign wb_rw_addr     = r_rw_addr;
  assign wb_data        = r_rdata;
  assign store_done     = r_store_done && !rst;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int REG_AW = nand_cpu_pkg::REG_AW;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready;
  nand_cpu_pkg::MemOp in_mem_op;
  logic [DATA_W-1:0] in_base, in_offset, in_store_data;
  logic              in_use_rw;
  logic [REG_AW-1:0] in_rw_addr;
  logic              dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [ADDR_W-1:0] dmem_req_addr;
  logic [DATA_W-1:0] dmem_req_wdata;
  logic              dmem_resp_valid;
  logic [DATA_W-1:0] dmem_resp_rdata;
  logic              wb_valid, wb_ready;
  logic [REG_AW-1:0] wb_rw_addr;
  logic [DATA_W-1:0] wb_data;
  logic              store_done, busy;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] mem [8];

  load_store_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mem_op(in_mem_op),
    .in_base(in_base), .in_offset(in_offset), .in_store_data(in_store_data),
    .in_use_rw(in_use_rw), .in_rw_addr(in_rw_addr),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rw_addr(wb_rw_addr),
    .wb_data(wb_data), .store_done(store_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input nand_cpu_pkg::MemOp op, input logic [15:0] base,
                       input logic [15:0] off, input logic [15:0] sdata,
                       input logic use_rw, input logic [REG_AW-1:0] rw);
    in_valid = 1'b1; in_mem_op = op; in_base = base; in_offset = off;
    in_store_data = sdata; in_use_rw = use_rw; in_rw_addr = rw;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_in_ready"}, {31'd0, in_ready}, 0);
    check_val({tag, "_req_valid"}, {31'd0, dmem_req_valid}, 0);
    check_val({tag, "_wb_valid"}, {31'd0, wb_valid}, 0);
    check_val({tag, "_store_done"}, {31'd0, store_done}, 0);
    check_val({tag, "_busy"}, {31'd0, busy}, 0);
    check_val({tag, "_req_we"}, {31'd0, dmem_req_we}, 0);
    check_val({tag, "_req_addr"}, {16'd0, dmem_req_addr}, 0);
    check_val({tag, "_req_wdata"}, {16'd0, dmem_req_wdata}, 0);
    check_val({tag, "_wb_data"}, {16'd0, wb_data}, 0);
    check_val({tag, "_wb_rw"}, {28'd0, wb_rw_addr}, 0);
  endtask

  // Random transaction: expected request fields and load results come from
  // the bench's own view of memory, indexed by the effective address.
  task automatic rand_op(input int n);
    int sel;
    logic [15:0] base, off, sdata, ea;
    logic [2:0] a;
    logic use_rw;
    logic [REG_AW-1:0] rw;
    int stall;
    sel    = $urandom_range(0, 4);
    a      = 3'($urandom_range(0, 7));
    base   = 16'($urandom);
    off    = 16'(a) - base;
    ea     = 16'(a);
    sdata  = 16'($urandom);
    use_rw = 1'($urandom_range(0, 1));
    rw     = REG_AW'($urandom_range(0, 15));
    check_val("r_in_ready", {31'd0, in_ready}, 1);
    if (sel == 4) issue(nand_cpu_pkg::MEM_FENCE, base, off, sdata, use_rw, rw);
    else if (sel >= 2) issue(nand_cpu_pkg::MEM_STORE, base, off, sdata, use_rw, rw);
    else issue(nand_cpu_pkg::MEM_LOAD, base, off, sdata, use_rw, rw);
    dmem_req_ready = 1'b0;
    wb_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    if (sel == 4) begin
      check_val("r_nop_busy", {31'd0, busy}, 0);
      check_val("r_nop_req", {31'd0, dmem_req_valid}, 0);
      return;
    end
    stall = $urandom_range(0, 3);
    for (int i = 0; i < stall; i++) begin
      check_val("r_req_valid_stall", {31'd0, dmem_req_valid}, 1);
      tick();
    end
    check_val("r_req_valid", {31'd0, dmem_req_valid}, 1);
    check_val("r_req_addr", {16'd0, dmem_req_addr}, {16'd0, ea});
    check_val("r_req_we", {31'd0, dmem_req_we}, (sel >= 2) ? 1 : 0);
    if (sel >= 2) check_val("r_req_wdata", {16'd0, dmem_req_wdata}, {16'd0, sdata});
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    if (sel >= 2) begin
      mem[a] = sdata;
      check_val("r_store_done", {31'd0, store_done}, 1);
      check_val("r_store_busy", {31'd0, busy}, 0);
      return;
    end
    stall = $urandom_range(0, 3);
    for (int i = 0; i < stall; i++) begin
      check_val("r_wait_busy", {31'd0, busy}, 1);
      tick();
    end
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = mem[a];
    tick();
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = 16'($urandom);
    if (!use_rw) begin
      check_val("r_norw_wb", {31'd0, wb_valid}, 0);
      check_val("r_norw_busy", {31'd0, busy}, 0);
      return;
    end
    stall = $urandom_range(0, 3);
    for (int i = 0; i <= stall; i++) begin
      check_val("r_wb_valid", {31'd0, wb_valid}, 1);
      check_val("r_wb_data", {16'd0, wb_data}, {16'd0, mem[a]});
      check_val("r_wb_rw", {28'd0, wb_rw_addr}, {28'd0, rw});
      if (i == stall) wb_ready = 1'b1;
      tick();
    end
    wb_ready = 1'b0;
    check_val("r_wb_done", {31'd0, wb_valid}, 0);
    if (n < 0) check_val("r_never", 0, 1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mem_op = nand_cpu_pkg::MEM_NONE;
    in_base = '0; in_offset = '0; in_store_data = '0; in_use_rw = 1'b0; in_rw_addr = '0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_rdata = '0; wb_ready = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    #1;
    check_val("post_rst_in_ready", {31'd0, in_ready}, 1);

    // Load, minimum latency with address wrap through a negative offset.
    issue(nand_cpu_pkg::MEM_LOAD, 16'h0010, 16'hFFFE, 16'h0, 1'b1, 4'd5);
    dmem_req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_val("ld_c1_req_valid", {31'd0, dmem_req_valid}, 1);
    check_val("ld_c1_addr", {16'd0, dmem_req_addr}, 32'h000E);
    check_val("ld_c1_we", {31'd0, dmem_req_we}, 0);
    check_val("ld_c1_in_ready", {31'd0, in_ready}, 0);
    tick();
    check_val("ld_c2_req_valid", {31'd0, dmem_req_valid}, 0);
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 16'hBEEF;
    tick();
    dmem_resp_valid = 1'b0;
    check_val("ld_c3_wb_valid", {31'd0, wb_valid}, 1);
    check_val("ld_c3_wb_rw", {28'd0, wb_rw_addr}, 5);
    check_val("ld_c3_wb_data", {16'd0, wb_data}, 32'hBEEF);
    tick();
    check_val("ld_c4_wb_valid", {31'd0, wb_valid}, 0);
    check_val("ld_c4_busy", {31'd0, busy}, 0);
    dmem_req_ready = 1'b0;

    // Store stalled three cycles, address wraps past 0xFFFF.
    issue(nand_cpu_pkg::MEM_STORE, 16'hFFFF, 16'h0002, 16'h1234, 1'b0, 4'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("st_stall_valid", {31'd0, dmem_req_valid}, 1);
      check_val("st_stall_addr", {16'd0, dmem_req_addr}, 32'h0001);
      check_val("st_stall_we", {31'd0, dmem_req_we}, 1);
      check_val("st_stall_wdata", {16'd0, dmem_req_wdata}, 32'h1234);
      check_val("st_stall_done", {31'd0, store_done}, 0);
      tick();
    end
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    check_val("st_done_pulse", {31'd0, store_done}, 1);
    check_val("st_req_drop", {31'd0, dmem_req_valid}, 0);
    check_val("st_wb", {31'd0, wb_valid}, 0);
    tick();
    check_val("st_done_single", {31'd0, store_done}, 0);

    // Flush in WAIT, response arrives later and is drained.
    issue(nand_cpu_pkg::MEM_LOAD, 16'h0100, 16'h0004, 16'h0, 1'b1, 4'd3);
    dmem_req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    dmem_req_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("drain_busy", {31'd0, busy}, 1);
      check_val("drain_in_ready", {31'd0, in_ready}, 0);
      check_val("drain_wb", {31'd0, wb_valid}, 0);
      tick();
    end
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 16'hDEAD;
    tick();
    dmem_resp_valid = 1'b0;
    check_val("drain_done_busy", {31'd0, busy}, 0);
    check_val("drain_done_wb", {31'd0, wb_valid}, 0);
    check_val("drain_done_in_ready", {31'd0, in_ready}, 1);

    // Flush in REQ before acceptance: load withdraws, store persists.
    issue(nand_cpu_pkg::MEM_LOAD, 16'h0200, 16'h0000, 16'h0, 1'b1, 4'd1);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("fl_req_ld_valid", {31'd0, dmem_req_valid}, 0);
    check_val("fl_req_ld_busy", {31'd0, busy}, 0);
    issue(nand_cpu_pkg::MEM_STORE, 16'h0300, 16'h0001, 16'h5A5A, 1'b0, 4'd0);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("fl_req_st_valid", {31'd0, dmem_req_valid}, 1);
    check_val("fl_req_st_addr", {16'd0, dmem_req_addr}, 32'h0301);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    check_val("fl_req_st_done", {31'd0, store_done}, 1);

    // Flush in IDLE blocks acceptance.
    issue(nand_cpu_pkg::MEM_LOAD, 16'h0, 16'h0, 16'h0, 1'b1, 4'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_val("fl_idle_busy", {31'd0, busy}, 0);
    check_val("fl_idle_req", {31'd0, dmem_req_valid}, 0);

    // Writeback held under backpressure; then use_rw=0 load.
    wb_ready = 1'b0;
    issue(nand_cpu_pkg::MEM_LOAD, 16'h0040, 16'h0001, 16'h0, 1'b1, 4'd9);
    dmem_req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 16'hA5A5;
    tick();
    dmem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_val("wb_hold_valid", {31'd0, wb_valid}, 1);
      check_val("wb_hold_data", {16'd0, wb_data}, 32'hA5A5);
      check_val("wb_hold_rw", {28'd0, wb_rw_addr}, 9);
      tick();
    end
    wb_ready = 1'b1;
    tick();
    check_val("wb_release", {31'd0, wb_valid}, 0);
    issue(nand_cpu_pkg::MEM_LOAD, 16'h0040, 16'h0002, 16'h0, 1'b0, 4'd2);
    dmem_req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 16'h7777;
    tick();
    dmem_resp_valid = 1'b0;
    check_val("norw_wb", {31'd0, wb_valid}, 0);
    check_val("norw_busy", {31'd0, busy}, 0);

    // Flush in WB with wb_ready high drops the result.
    issue(nand_cpu_pkg::MEM_LOAD, 16'h0050, 16'h0000, 16'h0, 1'b1, 4'd4);
    dmem_req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 16'h1111;
    wb_ready = 1'b0;
    tick();
    dmem_resp_valid = 1'b0;
    check_val("flwb_valid", {31'd0, wb_valid}, 1);
    flush = 1'b1; wb_ready = 1'b1;
    tick();
    flush = 1'b0;
    check_val("flwb_drop", {31'd0, wb_valid}, 0);
    check_val("flwb_busy", {31'd0, busy}, 0);

    // Reset in WAIT, then a stray response.
    issue(nand_cpu_pkg::MEM_LOAD, 16'h0060, 16'h0003, 16'h0, 1'b1, 4'd6);
    dmem_req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    dmem_req_ready = 1'b0;
    check_val("rstw_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    #1;
    check_val("rstw_in_ready_comb", {31'd0, in_ready}, 0);
    tick();
    check_all_zero("rst_wait");
    rst = 1'b0;
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 16'hCAFE;
    tick();
    dmem_resp_valid = 1'b0;
    check_val("stray_wb", {31'd0, wb_valid}, 0);
    check_val("stray_busy", {31'd0, busy}, 0);
    check_val("stray_data", {16'd0, wb_data}, 0);
    tick();
    check_val("stray_wb2", {31'd0, wb_valid}, 0);

    for (int n = 0; n < 200; n++) rand_op(n);
    wb_ready = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
